// File: rtl/dsc_pkg.sv
// Shared types and constants for the DSC encoder front end.
package dsc_pkg;

    localparam int DSC_BPC = 8;

    // Bit positions inside the 5-bit pixel position flag vector {eof, eos, eol, sol, sos}
    localparam int FLAG_SOS = 0;
    localparam int FLAG_SOL = 1;
    localparam int FLAG_EOL = 2;
    localparam int FLAG_EOS = 3;
    localparam int FLAG_EOF = 4;
    localparam int FLAG_W   = 5;

    typedef struct packed {
        logic [DSC_BPC-1:0] r;
        logic [DSC_BPC-1:0] g;
        logic [DSC_BPC-1:0] b;
    } dsc_pix_rgb_t;

    typedef struct packed {
        logic        [DSC_BPC-1:0] y;
        logic signed [DSC_BPC:0]   co;
        logic signed [DSC_BPC:0]   cg;
    } dsc_pix_ycc_t;

    // Field order matches the FLAG_* bit indices above
    typedef struct packed {
        logic eof;
        logic eos;
        logic eol;
        logic sol;
        logic sos;
    } dsc_pix_flags_t;

endpackage

// File: rtl/dsc_rgb2ycocg.sv
// Combinational lossless RGB -> YCoCg-R lifting transform.
// Chroma is BPC+1 bits two's complement; luma always lands in 0..2^BPC-1.
module dsc_rgb2ycocg #(
    parameter int BPC = 8
) (
    input  logic [BPC-1:0] i_r,
    input  logic [BPC-1:0] i_g,
    input  logic [BPC-1:0] i_b,
    output logic [BPC-1:0] o_y,
    output logic [BPC:0]   o_co,
    output logic [BPC:0]   o_cg
);

    // Every intermediate fits in BPC+1 signed bits, so modular arithmetic at
    // that width yields exact results without wider temporaries.
    logic signed [BPC:0] w_r;
    logic signed [BPC:0] w_g;
    logic signed [BPC:0] w_b;
    logic signed [BPC:0] w_co;
    logic signed [BPC:0] w_t;
    logic signed [BPC:0] w_cg;

    assign w_r  = $signed({1'b0, i_r});
    assign w_g  = $signed({1'b0, i_g});
    assign w_b  = $signed({1'b0, i_b});
    assign w_co = w_r - w_b;
    assign w_t  = w_b + (w_co >>> 1);
    assign w_cg = w_g - w_t;

    assign o_co = w_co;
    assign o_cg = w_cg;
    assign o_y  = BPC'(w_t + (w_cg >>> 1));

endmodule

// File: rtl/dsc_pixel_framer.sv
// Front stage of the DSC encoder: tags raster pixels with slice/line/frame
// position flags and converts them to YCoCg-R over a fixed 2-stage pipeline.
module dsc_pixel_framer
    import dsc_pkg::*;
#(
    parameter int BPC   = 8,
    parameter int DIM_W = 13
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIM_W-1:0] i_cfg_pic_w,
    input  logic [DIM_W-1:0] i_cfg_pic_h,
    input  logic [DIM_W-1:0] i_cfg_slice_w,
    input  logic [DIM_W-1:0] i_cfg_slice_h,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic             i_s_sof,
    input  logic [BPC-1:0]   i_s_r,
    input  logic [BPC-1:0]   i_s_g,
    input  logic [BPC-1:0]   i_s_b,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [BPC-1:0]   o_m_y,
    output logic [BPC:0]     o_m_co,
    output logic [BPC:0]     o_m_cg,
    output logic [4:0]       o_m_flags,
    output logic             o_frame_done,
    output logic [1:0]       o_err_sof
);

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    // Frame geometry captured on each accepted start-of-frame pixel
    logic [DIM_W-1:0] r_picW, r_picH, r_sliceW, r_sliceH;
    // Picture and in-slice position of the next pixel to be accepted
    logic [DIM_W-1:0] r_x, r_y, r_xs, r_ys;
    logic [1:0]       r_errSof;

    logic             r_s1Valid;
    logic [FLAG_W-1:0] r_s1Flags;
    logic [BPC-1:0]   r_s1Y;
    logic [BPC:0]     r_s1Co, r_s1Cg;

    logic             r_mValid;
    logic [FLAG_W-1:0] r_mFlags;
    logic [BPC-1:0]   r_mY;
    logic [BPC:0]     r_mCo, r_mCg;

    logic             w_en, w_accept;
    logic [DIM_W-1:0] w_picW, w_picH, w_sliceW, w_sliceH;
    logic [DIM_W-1:0] w_cx, w_cy, w_cxs, w_cys;
    logic             w_xLast, w_yLast, w_xsLast, w_ysLast;
    logic [FLAG_W-1:0] w_flags;
    logic [DIM_W-1:0] w_xNext, w_yNext, w_xsNext, w_ysNext;
    logic             w_atOrigin;
    logic [BPC-1:0]   w_y;
    logic [BPC:0]     w_co, w_cg;
    dsc_pix_flags_t   w_outFlags;

    // Both stages move together whenever the output register can be overwritten
    assign w_en      = !r_mValid || i_m_ready;
    assign o_s_ready = w_en && !i_rst;
    assign w_accept  = i_s_valid && o_s_ready;

    // A start-of-frame pixel uses the incoming geometry and origin position
    // immediately, so it is tagged as the first pixel even when it arrives early.
    assign w_picW   = i_s_sof ? i_cfg_pic_w   : r_picW;
    assign w_picH   = i_s_sof ? i_cfg_pic_h   : r_picH;
    assign w_sliceW = i_s_sof ? i_cfg_slice_w : r_sliceW;
    assign w_sliceH = i_s_sof ? i_cfg_slice_h : r_sliceH;
    assign w_cx     = i_s_sof ? '0 : r_x;
    assign w_cy     = i_s_sof ? '0 : r_y;
    assign w_cxs    = i_s_sof ? '0 : r_xs;
    assign w_cys    = i_s_sof ? '0 : r_ys;

    assign w_xLast  = (w_cx  == w_picW   - ONE);
    assign w_yLast  = (w_cy  == w_picH   - ONE);
    assign w_xsLast = (w_cxs == w_sliceW - ONE);
    assign w_ysLast = (w_cys == w_sliceH - ONE);

    assign w_atOrigin = (r_x == '0) && (r_y == '0);

    // Position flags; partial right/bottom slices close at the picture edge
    always_comb begin
        w_flags           = '0;
        w_flags[FLAG_SOL] = (w_cxs == '0);
        w_flags[FLAG_SOS] = (w_cxs == '0) && (w_cys == '0);
        w_flags[FLAG_EOL] = w_xsLast || w_xLast;
        w_flags[FLAG_EOS] = (w_xsLast || w_xLast) && (w_ysLast || w_yLast);
        w_flags[FLAG_EOF] = w_xLast && w_yLast;
    end

    // Raster walk: slice column wraps at slice end, row wraps at picture edge,
    // and everything returns to the origin after the last pixel of the frame
    always_comb begin
        w_xNext  = w_cx;
        w_yNext  = w_cy;
        w_xsNext = w_cxs;
        w_ysNext = w_cys;
        if (w_xLast && w_yLast) begin
            w_xNext  = '0;
            w_yNext  = '0;
            w_xsNext = '0;
            w_ysNext = '0;
        end else if (w_xLast) begin
            w_xNext  = '0;
            w_yNext  = w_cy + ONE;
            w_xsNext = '0;
            w_ysNext = (w_ysLast || w_yLast) ? '0 : w_cys + ONE;
        end else begin
            w_xNext  = w_cx + ONE;
            w_xsNext = w_flags[FLAG_EOL] ? '0 : w_cxs + ONE;
        end
    end

    // Position counters advance once per accepted pixel
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x  <= '0;
            r_y  <= '0;
            r_xs <= '0;
            r_ys <= '0;
        end else if (w_accept) begin
            r_x  <= w_xNext;
            r_y  <= w_yNext;
            r_xs <= w_xsNext;
            r_ys <= w_ysNext;
        end
    end

    // Geometry shadow is only reloaded by a start-of-frame pixel
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_picW   <= '0;
            r_picH   <= '0;
            r_sliceW <= '0;
            r_sliceH <= '0;
        end else if (w_accept && i_s_sof) begin
            r_picW   <= i_cfg_pic_w;
            r_picH   <= i_cfg_pic_h;
            r_sliceW <= i_cfg_slice_w;
            r_sliceH <= i_cfg_slice_h;
        end
    end

    // Sticky framing errors: bit0 early start-of-frame, bit1 missing start-of-frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_errSof <= '0;
        end else if (w_accept) begin
            if (i_s_sof && !w_atOrigin) begin
                r_errSof[0] <= 1'b1;
            end
            if (!i_s_sof && w_atOrigin) begin
                r_errSof[1] <= 1'b1;
            end
        end
    end

    dsc_rgb2ycocg #(
        .BPC (BPC)
    ) u_rgb2ycocg (
        .i_r  (i_s_r),
        .i_g  (i_s_g),
        .i_b  (i_s_b),
        .o_y  (w_y),
        .o_co (w_co),
        .o_cg (w_cg)
    );

    // Stage 1 holds the converted pixel and its flags; empty slots travel as bubbles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1Valid <= 1'b0;
            r_s1Flags <= '0;
            r_s1Y     <= '0;
            r_s1Co    <= '0;
            r_s1Cg    <= '0;
        end else if (w_en) begin
            r_s1Valid <= w_accept;
            r_s1Flags <= w_flags;
            r_s1Y     <= w_y;
            r_s1Co    <= w_co;
            r_s1Cg    <= w_cg;
        end
    end

    // Stage 2 is the output register presented to the slice buffer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mValid <= 1'b0;
            r_mFlags <= '0;
            r_mY     <= '0;
            r_mCo    <= '0;
            r_mCg    <= '0;
        end else if (w_en) begin
            r_mValid <= r_s1Valid;
            r_mFlags <= r_s1Flags;
            r_mY     <= r_s1Y;
            r_mCo    <= r_s1Co;
            r_mCg    <= r_s1Cg;
        end
    end

    assign w_outFlags   = dsc_pix_flags_t'(r_mFlags);
    assign o_frame_done = !i_rst && r_mValid && i_m_ready && w_outFlags.eof;

    assign o_m_valid = r_mValid;
    assign o_m_flags = r_mFlags;
    assign o_m_y     = r_mY;
    assign o_m_co    = r_mCo;
    assign o_m_cg    = r_mCg;
    assign o_err_sof = r_errSof;

endmodule

// File: tb/tb_dsc_pixel_framer.sv
// Directed bench for dsc_pixel_framer with a reference-model scoreboard.
module tb_dsc_pixel_framer;

    logic        clock = 1'b0;
    logic        reset;
    logic [12:0] cfgPicW, cfgPicH, cfgSliceW, cfgSliceH;
    logic        sValid, sReady, sSof;
    logic [7:0]  sR, sG, sB;
    logic        mValid, mReady;
    logic [7:0]  mY;
    logic [8:0]  mCo, mCg;
    logic [4:0]  mFlags;
    logic        frameDone;
    logic [1:0]  errSof;

    typedef struct {
        logic [7:0] y;
        logic [8:0] co;
        logic [8:0] cg;
        logic [4:0] flags;
        int         accCycle;
    } expT;

    expT        sbQ[$];
    logic [4:0] obsFlags[$];

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;
    int frameDoneCnt = 0;
    bit latCheck = 0;
    bit randReady = 0;

    // Reference model state: raster position and frame geometry seen at start-of-frame
    int mx = 0, my = 0, mpw = 0, mph = 0, msw = 0, msh = 0;
    logic [1:0] errExp = 2'b00;

    dsc_pixel_framer #(.BPC(8), .DIM_W(13)) dut (
        .i_clk         (clock),
        .i_rst         (reset),
        .i_cfg_pic_w   (cfgPicW),
        .i_cfg_pic_h   (cfgPicH),
        .i_cfg_slice_w (cfgSliceW),
        .i_cfg_slice_h (cfgSliceH),
        .i_s_valid     (sValid),
        .o_s_ready     (sReady),
        .i_s_sof       (sSof),
        .i_s_r         (sR),
        .i_s_g         (sG),
        .i_s_b         (sB),
        .o_m_valid     (mValid),
        .i_m_ready     (mReady),
        .o_m_y         (mY),
        .o_m_co        (mCo),
        .o_m_cg        (mCg),
        .o_m_flags     (mFlags),
        .o_frame_done  (frameDone),
        .o_err_sof     (errSof)
    );

    // Free-running clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int floorHalf(input int v);
        return (v >= 0) ? v / 2 : -((-v + 1) / 2);
    endfunction

    // Model of one accepted pixel: positions come from a plain raster walk,
    // slice position is derived by modulo rather than by counters
    task automatic modelAccept();
        expT e;
        int xs, ys, co, t, cg, yv;
        logic sol, sos, eol, eos, eof;
        if (sSof) begin
            if (mx != 0 || my != 0) errExp[0] = 1'b1;
            mx = 0; my = 0;
            mpw = int'(cfgPicW); mph = int'(cfgPicH);
            msw = int'(cfgSliceW); msh = int'(cfgSliceH);
        end else if (mx == 0 && my == 0) begin
            errExp[1] = 1'b1;
        end
        xs  = (msw > 0) ? mx % msw : mx;
        ys  = (msh > 0) ? my % msh : my;
        sol = (xs == 0);
        sos = sol && (ys == 0);
        eol = (xs == msw - 1) || (mx == mpw - 1);
        eos = eol && ((ys == msh - 1) || (my == mph - 1));
        eof = (mx == mpw - 1) && (my == mph - 1);
        co = int'(sR) - int'(sB);
        t  = int'(sB) + floorHalf(co);
        cg = int'(sG) - t;
        yv = t + floorHalf(cg);
        e.y = 8'(yv);
        e.co = 9'(co);
        e.cg = 9'(cg);
        e.flags = {eof, eos, eol, sol, sos};
        e.accCycle = cycle;
        sbQ.push_back(e);
        mx++;
        if (mx >= mpw) begin
            mx = 0;
            my++;
            if (my >= mph) my = 0;
        end
    endtask

    // One clock: inputs are already driven after the falling edge; observe,
    // score the output transfer and record the acceptance, then pass the rising edge
    task automatic applyStimulus(output bit acc);
        expT e;
        #1;
        acc = 1'b0;
        if (reset) begin
            checkOutput("s_ready in reset", {31'b0, sReady}, 32'd0);
            checkOutput("frame_done in reset", {31'b0, frameDone}, 32'd0);
        end else begin
            checkOutput("s_ready", {31'b0, sReady}, {31'b0, (!mValid || mReady)});
            checkOutput("err_sof", {30'b0, errSof}, {30'b0, errExp});
            if (mValid && mReady) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected output", 32'd1, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    obsFlags.push_back(mFlags);
                    checkOutput("m_y", {24'b0, mY}, {24'b0, e.y});
                    checkOutput("m_co", {23'b0, mCo}, {23'b0, e.co});
                    checkOutput("m_cg", {23'b0, mCg}, {23'b0, e.cg});
                    checkOutput("m_flags", {27'b0, mFlags}, {27'b0, e.flags});
                    checkOutput("frame_done", {31'b0, frameDone}, {31'b0, e.flags[4]});
                    if (latCheck) checkOutput("latency", cycle - e.accCycle, 32'd2);
                end
            end else begin
                checkOutput("frame_done idle", {31'b0, frameDone}, 32'd0);
            end
            if (frameDone) frameDoneCnt++;
            if (sValid && sReady) begin
                acc = 1'b1;
                modelAccept();
            end
        end
        cycle++;
        @(negedge clock);
    endtask

    task automatic sendPixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic sof);
        bit acc;
        acc = 1'b0;
        sR = r; sG = g; sB = b; sSof = sof; sValid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            if (randReady) mReady = 1'($urandom_range(0, 1));
            applyStimulus(acc);
        end
        if (!acc) checkOutput("accept timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int maxCycles);
        bit acc;
        sValid = 1'b0;
        sSof = 1'b0;
        for (int i = 0; i < maxCycles && sbQ.size() != 0; i++) begin
            mReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(acc);
        end
        checkOutput("drain empty", sbQ.size(), 32'd0);
        mReady = 1'b1;
    endtask

    task automatic setCfg(input int pw, input int ph, input int sw, input int sh);
        cfgPicW = 13'(pw); cfgPicH = 13'(ph); cfgSliceW = 13'(sw); cfgSliceH = 13'(sh);
    endtask

    initial begin
        bit acc;
        int c0;
        reset = 1'b1; sValid = 1'b0; sSof = 1'b0; sR = '0; sG = '0; sB = '0; mReady = 1'b1;
        setCfg(4, 2, 2, 1);
        repeat (3) applyStimulus(acc);
        reset = 1'b0;
        #1;
        checkOutput("reset m_valid", {31'b0, mValid}, 32'd0);
        checkOutput("reset m_y", {24'b0, mY}, 32'd0);
        checkOutput("reset m_co", {23'b0, mCo}, 32'd0);
        checkOutput("reset m_cg", {23'b0, mCg}, 32'd0);
        checkOutput("reset m_flags", {27'b0, mFlags}, 32'd0);
        checkOutput("reset err_sof", {30'b0, errSof}, 32'd0);

        $display("[TB] streaming 4x2 frame, slice 2x1");
        latCheck = 1'b1; frameDoneCnt = 0; obsFlags.delete();
        c0 = cycle;
        sendPixel(8'd255, 8'd0,   8'd0,   1'b1);
        sendPixel(8'd0,   8'd255, 8'd0,   1'b0);
        sendPixel(8'd128, 8'd128, 8'd128, 1'b0);
        sendPixel(8'd0,   8'd0,   8'd255, 1'b0);
        for (int i = 0; i < 4; i++)
            sendPixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        checkOutput("stream cycles", cycle - c0, 32'd8);
        drain(20);
        checkOutput("frame_done count", frameDoneCnt, 32'd1);
        checkOutput("pixel0 flags", {27'b0, obsFlags[0]}, 32'h03);
        checkOutput("pixel1 flags", {27'b0, obsFlags[1]}, 32'h0C);
        checkOutput("pixel7 flags", {27'b0, obsFlags[7]}, 32'h1C);
        latCheck = 1'b0;

        $display("[TB] 5x3 frame, slice 2x2, geometry changed mid-frame");
        setCfg(5, 3, 2, 2);
        obsFlags.delete();
        for (int i = 0; i < 15; i++) begin
            sendPixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i == 0);
            if (i == 0) setCfg(7, 9, 3, 4);
        end
        drain(20);
        checkOutput("x4 y0 flags", {27'b0, obsFlags[4]}, 32'h07);
        checkOutput("x4 y1 flags", {27'b0, obsFlags[9]}, 32'h0E);
        checkOutput("x1 y2 flags", {27'b0, obsFlags[11]}, 32'h0C);
        checkOutput("x4 y2 flags", {27'b0, obsFlags[14]}, 32'h1F);

        $display("[TB] random backpressure, two 4x2 frames");
        setCfg(4, 2, 2, 1);
        randReady = 1'b1; frameDoneCnt = 0;
        for (int i = 0; i < 16; i++) begin
            sendPixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), (i % 8) == 0);
            if ($urandom_range(0, 3) == 0) begin
                sValid = 1'b0;
                mReady = 1'($urandom_range(0, 1));
                applyStimulus(acc);
            end
        end
        drain(100);
        checkOutput("random frame_done count", frameDoneCnt, 32'd2);
        randReady = 1'b0;

        $display("[TB] framing errors");
        obsFlags.delete();
        for (int i = 0; i < 4; i++)
            sendPixel(8'(i * 10), 8'(i * 20), 8'(i * 30), (i == 0) || (i == 3));
        drain(20);
        checkOutput("early sof err", {30'b0, errSof}, 32'h1);
        checkOutput("early sof flags", {27'b0, obsFlags[3]}, 32'h03);
        for (int i = 0; i < 7; i++)
            sendPixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        sendPixel(8'd1, 8'd2, 8'd3, 1'b0);
        drain(20);
        checkOutput("missing sof err", {30'b0, errSof}, 32'h3);

        $display("[TB] reset with two pixels in flight");
        setCfg(1, 1, 1, 1);
        frameDoneCnt = 0;
        sendPixel(8'd10, 8'd20, 8'd30, 1'b1);
        sendPixel(8'd40, 8'd50, 8'd60, 1'b1);
        sValid = 1'b0; sSof = 1'b0;
        reset = 1'b1;
        sbQ.delete();
        mx = 0; my = 0; mpw = 0; mph = 0; msw = 0; msh = 0; errExp = 2'b00;
        applyStimulus(acc);
        reset = 1'b0;
        #1;
        checkOutput("post-reset m_valid", {31'b0, mValid}, 32'd0);
        checkOutput("post-reset frame_done", {31'b0, frameDone}, 32'd0);
        checkOutput("post-reset err_sof", {30'b0, errSof}, 32'd0);
        repeat (4) applyStimulus(acc);
        checkOutput("no frame_done after reset", frameDoneCnt, 32'd0);
        sendPixel(8'd7, 8'd8, 8'd9, 1'b1);
        drain(20);
        checkOutput("recovered frame_done", frameDoneCnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
